// File: rtl/debounce_pkg.sv
// Shared defaults and per-channel state type for the button debounce bank.
// Optional hold auto-repeat is enabled by defining HOLD_REPEAT_EN.
package debounce_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 500;
  localparam int DEF_REPEAT_PERIOD   = 100;

  typedef enum logic {
    ST_STABLE,
    ST_COUNTING
  } db_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, ENABLE-gated debounce counter,
// registered level with rise/fall pulses, optional hold auto-repeat
// (compiled in when HOLD_REPEAT_EN is defined).
//
// state       | meaning
// ST_STABLE   | synchronised input equals accepted level, counter held at 0
// ST_COUNTING | synchronised input differs, counting ENABLE ticks toward acceptance
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic rst_n,
  input  logic btn_in,
  input  logic enable,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("debounce_channel: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  db_state_e              state;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw asynchronous level through the synchroniser chain.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  // Channel state follows directly from synchronised input versus accepted level.
  always_comb begin
    state = (s == level_q) ? ST_STABLE : ST_COUNTING;
  end

  // Debounce next-state: any bounce back to the level aborts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state)
      ST_STABLE: cnt_d = '0;
      ST_COUNTING: begin
        if (enable) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Debounce state register; pulses line up with the first cycle of the new level.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef HOLD_REPEAT_EN
  localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] rep_last;
  logic             rep_first_q, rep_first_d;
  logic             repeat_q, repeat_d;

  // Repeat next-state: count ticks only while the level is held high across the edge,
  // so the rise cycle starts from zero and a falling edge suppresses any pulse.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    repeat_d    = 1'b0;
    rep_last    = rep_first_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
    if (!(level_q && level_d)) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else if (enable) begin
      if (rep_cnt_q == rep_last) begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        repeat_d    = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  // Repeat counter and pulse register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      repeat_q    <= repeat_d;
    end
  end

  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/debounce_sync_bank.sv
// Bank of independent debounced button channels between board buttons and
// the menu/game/volume logic. Hold auto-repeat is built when HOLD_REPEAT_EN is defined.
module debounce_sync_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = 5,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] BTN_IN,
  input  logic                ENABLE,
  output logic [CHANNELS-1:0] BTN_LEVEL,
  output logic [CHANNELS-1:0] BTN_RISE,
  output logic [CHANNELS-1:0] BTN_FALL,
  output logic [CHANNELS-1:0] BTN_REPEAT
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clock     (CLOCK),
      .rst_n     (RESET_N),
      .btn_in    (BTN_IN[i]),
      .enable    (ENABLE),
      .btn_level (BTN_LEVEL[i]),
      .btn_rise  (BTN_RISE[i]),
      .btn_fall  (BTN_FALL[i]),
      .btn_repeat(BTN_REPEAT[i])
    );
  end

endmodule

// File: tb/tb_debounce_sync_bank.sv
// Bench for debounce_sync_bank: directed scenarios plus random stimulus
// compared every cycle against a run-length reference model.
module tb_debounce_sync_bank;

  localparam int CH = 5;
  localparam int SS = 2;
  localparam int DC = 16;
  localparam int RD = 5;
  localparam int RP = 3;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [CH-1:0] BTN_IN = '0;
  logic          ENABLE = 1'b0;
  logic [CH-1:0] BTN_LEVEL, BTN_RISE, BTN_FALL, BTN_REPEAT;

  int n_assert = 0;
  int n_fail   = 0;

  debounce_sync_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .BTN_IN(BTN_IN), .ENABLE(ENABLE),
    .BTN_LEVEL(BTN_LEVEL), .BTN_RISE(BTN_RISE), .BTN_FALL(BTN_FALL), .BTN_REPEAT(BTN_REPEAT)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: delay line for the synchroniser, run length of ENABLE ticks
  // during which the synchronised input has disagreed with the level, and the
  // number of ENABLE ticks the level has been held high.
  logic [CH-1:0] sync_m [SS];
  int            run_m  [CH];
  int            hold_m [CH];
  logic [CH-1:0] lvl_m, rise_m, fall_m, rep_m;

  task automatic model_clear();
    for (int i = 0; i < SS; i++) sync_m[i] = '0;
    for (int c = 0; c < CH; c++) begin run_m[c] = 0; hold_m[c] = 0; end
    lvl_m = '0; rise_m = '0; fall_m = '0; rep_m = '0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] s;
    logic [CH-1:0] nl;
    s = sync_m[SS-1];
    nl = lvl_m;
    rise_m = '0; fall_m = '0; rep_m = '0;
    for (int c = 0; c < CH; c++) begin
      if (s[c] != lvl_m[c]) begin
        if (ENABLE) begin
          run_m[c]++;
          if (run_m[c] == DC) begin
            nl[c] = s[c];
            if (s[c]) rise_m[c] = 1'b1; else fall_m[c] = 1'b1;
            run_m[c] = 0;
          end
        end
      end else begin
        run_m[c] = 0;
      end
`ifdef HOLD_REPEAT_EN
      if (lvl_m[c] && nl[c]) begin
        if (ENABLE) begin
          hold_m[c]++;
          if (hold_m[c] == RD || (hold_m[c] > RD && (hold_m[c] - RD) % RP == 0)) rep_m[c] = 1'b1;
        end
      end else begin
        hold_m[c] = 0;
      end
`endif
    end
    lvl_m = nl;
    for (int i = SS - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
    sync_m[0] = BTN_IN;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("model_level",  32'(BTN_LEVEL),  32'(lvl_m));
    chk("model_rise",   32'(BTN_RISE),   32'(rise_m));
    chk("model_fall",   32'(BTN_FALL),   32'(fall_m));
    chk("model_repeat", 32'(BTN_REPEAT), 32'(rep_m));
  endtask

  // Advance n clock cycles; inputs stay stable from the previous falling edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK);
      if (!RESET_N) model_clear(); else model_edge();
      @(negedge CLOCK);
      check_all();
    end
  endtask

  initial begin
    int ticks;
    bit lvl_seen;
    logic [15:0] mask;
    int post_rep;

    model_clear();

    // Reset with all buttons pressed, then latency after release
    BTN_IN = 5'b11111; ENABLE = 1'b1; RESET_N = 1'b0;
    cyc(3);
    chk("rst_level", 32'(BTN_LEVEL), 32'h0);
    chk("rst_rise",  32'(BTN_RISE),  32'h0);
    RESET_N = 1'b1;
    cyc(17);
    chk("lat_pre_level", 32'(BTN_LEVEL), 32'h0);
    cyc(1);
    chk("lat_level", 32'(BTN_LEVEL), 32'h1F);
    chk("lat_rise",  32'(BTN_RISE),  32'h1F);
    cyc(1);
    chk("lat_rise_single", 32'(BTN_RISE), 32'h0);

    // Bounce on channel 0
    BTN_IN = '0;
    cyc(20);
    chk("all_released", 32'(BTN_LEVEL), 32'h0);
    BTN_IN = 5'b00001; cyc(10);
    BTN_IN = 5'b00000; cyc(3);
    BTN_IN = 5'b00001; cyc(17);
    chk("bounce_hold", 32'(BTN_LEVEL), 32'h0);
    cyc(1);
    chk("bounce_level", 32'(BTN_LEVEL), 32'h01);
    chk("bounce_rise",  32'(BTN_RISE),  32'h01);

    // ENABLE gating on channel 2: one tick in four
    BTN_IN = 5'b00101;
    ticks = 0; lvl_seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      ENABLE = (k % 4 == 3);
      cyc(1);
      if (ENABLE) ticks++;
      if (BTN_LEVEL[2] && !lvl_seen) begin
        lvl_seen = 1'b1;
        chk("gate_on_tick",    32'(ENABLE), 32'h1);
        chk("gate_tick_count", 32'(ticks),  32'd16);
      end
    end
    chk("gate_level_seen", 32'(lvl_seen), 32'h1);
    ENABLE = 1'b0; BTN_IN = 5'b00001;
    cyc(30);
    chk("gate_frozen", 32'(BTN_LEVEL[2]), 32'h1);

    // Simultaneous rise on ch1 and fall on ch3
    ENABLE = 1'b1; BTN_IN = 5'b01000;
    cyc(25);
    chk("simul_pre", 32'(BTN_LEVEL), 32'h08);
    BTN_IN = 5'b00010;
    cyc(17);
    chk("simul_early_rise", 32'(BTN_RISE), 32'h0);
    cyc(1);
    chk("simul_rise", 32'(BTN_RISE), 32'h02);
    chk("simul_fall", 32'(BTN_FALL), 32'h08);

    // Reset in the middle of a count on ch4
    BTN_IN = 5'b10010;
    cyc(10);
    RESET_N = 1'b0;
    #1;
    chk("midrst_level", 32'(BTN_LEVEL), 32'h0);
    chk("midrst_rise",  32'(BTN_RISE),  32'h0);
    model_clear();
    @(negedge CLOCK);
    cyc(1);
    RESET_N = 1'b1;
    cyc(17);
    chk("midrst_no_pulse", 32'(BTN_RISE | BTN_FALL), 32'h0);
    chk("midrst_pre",      32'(BTN_LEVEL),           32'h0);
    cyc(1);
    chk("midrst_level_up", 32'(BTN_LEVEL), 32'h12);
    chk("midrst_rise_up",  32'(BTN_RISE),  32'h12);

    // Hold auto-repeat on ch0
    BTN_IN = '0;
    cyc(20);
    BTN_IN = 5'b00001;
    cyc(18);
    chk("rep_rise", 32'(BTN_RISE), 32'h01);
    mask = '0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      mask[k] = BTN_REPEAT[0];
    end
`ifdef HOLD_REPEAT_EN
    chk("rep_mask", 32'(mask), 32'h0920);
`else
    chk("rep_mask", 32'(mask), 32'h0000);
`endif
    BTN_IN = '0;
    cyc(18);
    chk("rep_fall", 32'(BTN_FALL), 32'h01);
    post_rep = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (BTN_REPEAT[0]) post_rep++;
    end
    chk("rep_after_release", 32'(post_rep), 32'h0);

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 29) == 0) BTN_IN[c] = ~BTN_IN[c];
      ENABLE  = ($urandom_range(0, 3) != 0);
      RESET_N = ($urandom_range(0, 599) != 0);
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync_bank.md
Name: debounce_sync_bank

Overview:
- Parametrised successor to the single-bit D flip-flop used for button sampling.
- CHANNELS independent inputs per instance; each channel has:
  - a multi-stage synchroniser;
  - an ENABLE-gated debounce counter;
  - a registered debounced level plus single-cycle rise/fall pulses.
- Sits between the board push-buttons/switches and the menu, game and volume control logic.

Parameters:
- CHANNELS, 5, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 16, consecutive ENABLE ticks of a stable new value needed to accept it (>=1).
- REPEAT_DELAY, 500, ENABLE ticks from accepted press to first repeat pulse (only with HOLD_REPEAT_EN).
- REPEAT_PERIOD, 100, ENABLE ticks between subsequent repeat pulses (only with HOLD_REPEAT_EN).

Ports:
- CLOCK  input  1  system clock; all state updates on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- BTN_IN  input  CHANNELS  raw asynchronous button levels.
- ENABLE  input  1  sample tick; debounce (and repeat) counters advance only when 1.
- BTN_LEVEL  output  CHANNELS  debounced registered level.
- BTN_RISE  output  CHANNELS  one-cycle pulse when BTN_LEVEL goes 0->1.
- BTN_FALL  output  CHANNELS  one-cycle pulse when BTN_LEVEL goes 1->0.
- BTN_REPEAT  output  CHANNELS  auto-repeat pulses while held; constant 0 without HOLD_REPEAT_EN.

Behaviour:
- Reset (RESET_N=0, asynchronous, any time including mid-count): clear all of the following:
  - synchroniser flops, counters, BTN_LEVEL, BTN_RISE, BTN_FALL, BTN_REPEAT all go to 0;
  - no pulses are generated on reset release.
- Synchroniser: BTN_IN[i] shifts through SYNC_STAGES flops. s[i] is the last stage.
- Per-channel states:
  - STABLE (s==level, cnt==0);
  - COUNTING (s!=level).
- Counter width: CNT_W = $clog2(DEBOUNCE_CYCLES+1).
- Transitions, each clock edge:
  - s==level: cnt<=0, independent of ENABLE. A bounce back aborts the count.
  - s!=level, ENABLE=0: cnt holds.
  - s!=level, ENABLE=1, cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s!=level, ENABLE=1, cnt==DEBOUNCE_CYCLES-1: level<=s, cnt<=0, and the matching RISE or FALL is 1 for exactly that next cycle.
- Pulses are registered and coincide with the first cycle BTN_LEVEL shows the new value. RISE and FALL are never both 1 on the same channel.
- Latency (ENABLE tied 1): BTN_LEVEL changes SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples the new value. Defaults give 18 edges.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- No counter wrap: cnt saturates by design at DEBOUNCE_CYCLES-1 before acceptance.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined:
  - Each channel gets a repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)), cleared when BTN_LEVEL=0 or on the cycle of BTN_RISE.
  - While BTN_LEVEL=1 the counter counts ENABLE ticks.
  - BTN_REPEAT pulses for 1 cycle at REPEAT_DELAY ticks after the rise, then every REPEAT_PERIOD ticks.
  - Repeat stops the cycle BTN_LEVEL falls.
  - BTN_RISE itself is not a repeat pulse.
- Undefined: no repeat logic is synthesised; BTN_REPEAT = 0 constantly.

Decomposition:
- Shared package debounce_pkg holds:
  - default constants for SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD;
  - the per-channel state enum {ST_STABLE, ST_COUNTING}.
- One sub-module, debounce_channel: synchroniser, counter, level/pulse regs and optional repeat logic for one bit.
- debounce_sync_bank is a generate loop over CHANNELS instances.

Test Plan:
- Reset: hold RESET_N=0 with BTN_IN=5'b11111 -> all outputs 0. Release with ENABLE=1 -> BTN_LEVEL=5'b11111 exactly 18 edges later, BTN_RISE=5'b11111 for 1 cycle.
- Bounce: BTN_IN[0] high 10 cycles, low 3, then high -> no BTN_LEVEL change during the bounce. BTN_LEVEL[0]=1 exactly 18 edges after the final rise, single BTN_RISE[0] pulse.
- ENABLE gating: ENABLE=1 one cycle in 4, BTN_IN[2] 0->1 and held -> BTN_LEVEL[2] changes only on an ENABLE cycle, after the 16th tick. Nothing changes while ENABLE stays 0.
- Simultaneous: BTN_IN[1] 0->1 and BTN_IN[3] 1->0 on the same edge (ch3 pre-debounced high) -> BTN_RISE[1] and BTN_FALL[3] high in the same cycle, other pulses 0.
- Reset mid-count: BTN_IN[4] high, RESET_N low after 10 edges for 1 cycle -> cnt and level 0. Level rises 18 edges after release, with no pulse on reset release itself.
- HOLD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=3, ENABLE=1: hold BTN_IN[0] -> BTN_REPEAT[0] pulses at 5, 8, 11 cycles after BTN_RISE[0]. Release -> no further pulses. Without the macro, BTN_REPEAT stays 0.
